// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the icache handshake, buffers one
// instruction across stalls and drains misses before redirecting. Optional BTB: FETCH_BTB_EN.
module fetch_stage #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        btb_update,
  input  logic [31:0] btb_pc,
  input  logic [31:0] btb_target,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] npc_o,
  output logic [31:0] curr_pc_o,
  output logic        pred_taken_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] HOLD   = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;

  localparam logic [31:0] ALIGN  = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_RST = PC_INIT & ALIGN;

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] hold_instr;
  logic [31:0] pending_pc;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] redirect_aligned;
  logic        btb_hit;

  assign pc_plus4         = pc + 32'd4;
  assign redirect_aligned = redirect_pc & ALIGN;

`ifdef FETCH_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
  logic [31:0]            btb_tgt [BTB_ENTRIES];
  logic [IDX_W-1:0]       rd_idx;
  logic [IDX_W-1:0]       wr_idx;
  logic                   btb_unused;

  assign rd_idx     = pc[IDX_W+1:2];
  assign wr_idx     = btb_pc[IDX_W+1:2];
  assign btb_unused = ^btb_pc[1:0];
  assign btb_hit    = btb_valid[rd_idx] && (btb_tag[rd_idx] == pc[31:IDX_W+2]);
  assign next_pc    = btb_hit ? btb_tgt[rd_idx] : pc_plus4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      btb_valid <= '0;
    end else if (btb_update) begin
      btb_valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/target storage needs no reset: entries are qualified by btb_valid.
  always_ff @(posedge CLK) begin
    if (btb_update) begin
      btb_tag[wr_idx] <= btb_pc[31:IDX_W+2];
      btb_tgt[wr_idx] <= btb_target & ALIGN;
    end
  end
`else
  logic btb_unused;

  assign btb_unused = ^{btb_update, btb_pc, btb_target, BTB_ENTRIES[0]};
  assign btb_hit    = 1'b0;
  assign next_pc    = pc_plus4;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      pc         <= PC_RST;
      hold_instr <= '0;
      pending_pc <= PC_RST;
    end else if (halt) begin
      state <= HALTED;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (ihit) begin
            if (redirect) begin
              pc <= redirect_aligned;
            end else if (stall) begin
              hold_instr <= iload;
              state      <= HOLD;
            end else begin
              pc <= next_pc;
            end
          end else if (redirect) begin
            pending_pc <= redirect_aligned;
            state      <= DRAIN;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= redirect_aligned;
            state <= FETCH;
          end else if (!stall) begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        // The old request must complete before the new address may be issued.
        DRAIN: begin
          if (ihit) begin
            pc    <= redirect ? redirect_aligned : pending_pc;
            state <= FETCH;
          end else if (redirect) begin
            pending_pc <= redirect_aligned;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iREN    = 1'b0;
    valid_o = 1'b0;
    instr_o = '0;
    case (state)
      FETCH: begin
        iREN    = 1'b1;
        valid_o = ihit & ~stall & ~redirect & ~halt;
        if (valid_o) begin
          instr_o = iload;
        end
      end
      HOLD: begin
        valid_o = ~stall & ~redirect & ~halt;
        instr_o = hold_instr;
      end
      DRAIN: iREN = 1'b1;
      default: begin
        iREN    = 1'b0;
        valid_o = 1'b0;
      end
    endcase
  end

  assign iaddr        = pc;
  assign curr_pc_o    = pc;
  assign npc_o        = pc_plus4;
  assign pred_taken_o = valid_o & btb_hit;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the icache model returns 32'h1111_0000+addr, and every
// instruction expected on the IF/ID side is queued when its stimulus is driven.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit, stall, redirect, halt;
  logic [31:0] redirect_pc;
  logic        btb_update;
  logic [31:0] btb_pc, btb_target;
  logic [31:0] iload, iaddr, instr_o, npc_o, curr_pc_o;
  logic        iREN, valid_o, pred_taken_o;

  logic [31:0] w_iload, w_iaddr, w_instr, w_npc, w_curr;
  logic        w_iREN, w_valid, w_pred;

`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } exp_t;

  exp_t sb[$];
  exp_t sb_head;
  int   checks = 0;
  int   passes = 0;
  logic [31:0] hp;

  always #5 CLK = ~CLK;

  assign iload   = 32'h1111_0000 + iaddr;
  assign w_iload = 32'h1111_0000 + w_iaddr;

  fetch_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .btb_update(btb_update), .btb_pc(btb_pc), .btb_target(btb_target),
    .valid_o(valid_o), .instr_o(instr_o), .npc_o(npc_o), .curr_pc_o(curr_pc_o),
    .pred_taken_o(pred_taken_o)
  );

  fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) u_wrap (
    .CLK(CLK), .nRST(nRST), .ihit(1'b1), .iload(w_iload), .iREN(w_iREN), .iaddr(w_iaddr),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0), .halt(1'b0),
    .btb_update(1'b0), .btb_pc(32'h0), .btb_target(32'h0),
    .valid_o(w_valid), .instr_o(w_instr), .npc_o(w_npc), .curr_pc_o(w_curr),
    .pred_taken_o(w_pred)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic ih, input logic st, input logic rd,
                               input logic [31:0] rpc, input logic ht);
    ihit        = ih;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = ht;
  endtask

  task automatic pushExp(input logic [31:0] p, input logic pr);
    exp_t e;
    e.pc    = p;
    e.instr = 32'h1111_0000 + p;
    e.pred  = pr;
    sb.push_back(e);
  endtask

  task automatic nextCycle;
    @(posedge CLK);
    #1;
  endtask

  // Every instruction accepted by IF/ID must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (nRST && valid_o) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_valid", 32'(valid_o), 32'd0);
      end else begin
        sb_head = sb.pop_front();
        checkOutput("sb_pc", curr_pc_o, sb_head.pc);
        checkOutput("sb_instr", instr_o, sb_head.instr);
        checkOutput("sb_npc", npc_o, sb_head.pc + 32'd4);
        checkOutput("sb_pred", 32'(pred_taken_o), 32'(sb_head.pred));
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    btb_update = 1'b0;
    btb_pc     = 32'h0;
    btb_target = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_iREN", 32'(iREN), 32'd0);
    checkOutput("rst_iaddr", iaddr, 32'h0);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_instr", instr_o, 32'h0);
    checkOutput("rst_curr_pc", curr_pc_o, 32'h0);
    checkOutput("rst_npc", npc_o, 32'h4);
    checkOutput("rst_pred", 32'(pred_taken_o), 32'd0);
    checkOutput("wrap_rst_curr", w_curr, 32'hFFFF_FFFC);
    checkOutput("wrap_rst_npc", w_npc, 32'h0);
    nextCycle;
    nRST = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    checkOutput("idle_iREN", 32'(iREN), 32'd0);
    checkOutput("idle_valid", 32'(valid_o), 32'd0);
    nextCycle;

    pushExp(32'h0, 1'b0);
    @(negedge CLK);
    checkOutput("fetch_iREN", 32'(iREN), 32'd1);
    checkOutput("fetch_iaddr0", iaddr, 32'h0);
    checkOutput("wrap_valid", 32'(w_valid), 32'd1);
    checkOutput("wrap_curr0", w_curr, 32'hFFFF_FFFC);
    checkOutput("wrap_npc0", w_npc, 32'h0);
    checkOutput("wrap_instr0", w_instr, 32'h1110_FFFC);
    nextCycle;
    pushExp(32'h4, 1'b0);
    @(negedge CLK);
    checkOutput("wrap_curr1", w_curr, 32'h0);
    checkOutput("wrap_npc1", w_npc, 32'h4);
    nextCycle;

    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    checkOutput("stall_valid", 32'(valid_o), 32'd0);
    checkOutput("stall_instr", instr_o, 32'h0);
    nextCycle;
    repeat (2) begin
      @(negedge CLK);
      checkOutput("hold_iREN", 32'(iREN), 32'd0);
      checkOutput("hold_instr", instr_o, 32'h1111_0008);
      checkOutput("hold_valid", 32'(valid_o), 32'd0);
      nextCycle;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    pushExp(32'h8, 1'b0);
    @(negedge CLK);
    checkOutput("hold_release_valid", 32'(valid_o), 32'd1);
    nextCycle;
    pushExp(32'hC, 1'b0);
    @(negedge CLK);
    checkOutput("after_hold_iaddr", iaddr, 32'hC);
    nextCycle;

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    checkOutput("miss_iaddr", iaddr, 32'h10);
    checkOutput("miss_iREN", 32'(iREN), 32'd1);
    nextCycle;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    @(negedge CLK);
    checkOutput("miss_redir_iaddr", iaddr, 32'h10);
    checkOutput("miss_redir_valid", 32'(valid_o), 32'd0);
    nextCycle;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) begin
      @(negedge CLK);
      checkOutput("drain_iaddr", iaddr, 32'h10);
      checkOutput("drain_iREN", 32'(iREN), 32'd1);
      nextCycle;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    checkOutput("drain_hit_iaddr", iaddr, 32'h10);
    checkOutput("drain_hit_valid", 32'(valid_o), 32'd0);
    nextCycle;
    pushExp(32'h40, 1'b0);
    @(negedge CLK);
    checkOutput("redir_iaddr", iaddr, 32'h40);
    nextCycle;

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
    @(negedge CLK);
    checkOutput("hit_redir_valid", 32'(valid_o), 32'd0);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    pushExp(32'h80, 1'b0);
    @(negedge CLK);
    checkOutput("hit_redir_iaddr", iaddr, 32'h80);
    nextCycle;

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    btb_update = 1'b1;
    btb_pc     = 32'h8;
    btb_target = 32'h100;
    @(negedge CLK);
    checkOutput("btb_wr_valid", 32'(valid_o), 32'd0);
    nextCycle;
    btb_update = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    pushExp(32'h0, 1'b0);
    nextCycle;
    pushExp(32'h4, 1'b0);
    nextCycle;
    pushExp(32'h8, BTB_ON);
    nextCycle;
    pushExp(BTB_ON ? 32'h100 : 32'hC, 1'b0);
    nextCycle;
    hp = BTB_ON ? 32'h104 : 32'h10;

    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    checkOutput("pre_halt_iaddr", iaddr, hp);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge CLK);
    checkOutput("halt_hold_valid", 32'(valid_o), 32'd0);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) begin
      @(negedge CLK);
      checkOutput("halted_valid", 32'(valid_o), 32'd0);
      checkOutput("halted_iREN", 32'(iREN), 32'd0);
      nextCycle;
    end

    nRST = 1'b0;
    @(negedge CLK);
    checkOutput("rst2_iaddr", iaddr, 32'h0);
    checkOutput("rst2_curr_pc", curr_pc_o, 32'h0);
    nextCycle;
    nRST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    checkOutput("rst2_idle_iREN", 32'(iREN), 32'd0);
    nextCycle;
    @(negedge CLK);
    checkOutput("rst2_fetch_iREN", 32'(iREN), 32'd1);
    nextCycle;
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("rst_mid_miss_iREN", 32'(iREN), 32'd0);
    checkOutput("rst_mid_miss_iaddr", iaddr, 32'h0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline latch. It owns the program counter and runs the instruction-cache request handshake. It absorbs hazard stalls with a one-entry hold buffer and applies branch/jump redirects from later stages, draining any in-flight cache miss first. Each cycle it presents `instr`, `npc` and `curr_pc` plus a valid strobe that drives the latch's enable.

## Interface
- `PC_INIT`, 32'h0000_0000, reset value of the PC (word aligned).
- `BTB_ENTRIES`, 8, BTB depth; power of two, ≥2; used only when `FETCH_BTB_EN` is defined.

Ports:
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `ihit`  in  1  icache returns `iload` for `iaddr` this cycle.
- `iload`  in  32  instruction data.
- `iREN`  out  1  icache read request.
- `iaddr`  out  32  icache word address.
- `stall`  in  1  downstream freeze (hazard unit).
- `redirect`  in  1  branch/jump resolved; flush fetch.
- `redirect_pc`  in  32  new fetch address.
- `halt`  in  1  stop fetching permanently.
- `btb_update`  in  1  BTB write strobe.
- `btb_pc`  in  32  PC of the resolved taken branch.
- `btb_target`  in  32  target of that branch.
- `valid_o`  out  1  instruction handed to IF/ID this cycle (drives latch enable).
- `instr_o`  out  32  instruction.
- `npc_o`  out  32  `curr_pc_o + 4`.
- `curr_pc_o`  out  32  address of `instr_o`.
- `pred_taken_o`  out  1  next PC came from a BTB hit.

## Operation
States: IDLE, FETCH, HOLD, DRAIN, HALTED.

Registers: `pc`, `hold_instr`, `pending_pc`.

Address and arithmetic rules:
- All addresses are forced to word alignment (bits [1:0] = 0).
- `pc+4` wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0).
- `next_pc` = `pc+4`, or the BTB target on a hit (see Configuration).

Icache rule: once `iREN=1` is asserted with an address, that address is held until `ihit`.

State behaviour:
- **IDLE** (one cycle after reset): `iREN=0`, `valid_o=0`; go to FETCH.
- **FETCH**: `iREN=1`, `iaddr=pc`.
  - `ihit` & !`stall` & !`redirect`: `valid_o=1` with `instr_o=iload`; `pc<=next_pc`; stay in FETCH.
  - `ihit` & `stall` & !`redirect`: `hold_instr<=iload`; go to HOLD.
  - `ihit` & `redirect`: response discarded, `valid_o=0`; `pc<=redirect_pc`; stay in FETCH.
  - !`ihit` & `redirect`: `pending_pc<=redirect_pc`; go to DRAIN.
- **HOLD**: `iREN=0`, `instr_o=hold_instr`, `valid_o=!stall & !redirect`.
  - Presented (`valid_o=1`): `pc<=next_pc`; go to FETCH.
  - `redirect`: buffer dropped; `pc<=redirect_pc`; go to FETCH.
- **DRAIN**: `iREN=1`, `iaddr=pc` (old address), `valid_o=0`.
  - `redirect` overwrites `pending_pc`.
  - On `ihit`: data discarded; `pc<=pending_pc` (or `redirect_pc` if it arrives in the same cycle); go to FETCH.
- **HALTED**: `iREN=0`, `valid_o=0`; left only by reset. `halt` takes priority over everything from any state: the current response is not presented.

Output defaults:
- `instr_o=0` whenever `valid_o=0`, except in HOLD.
- `curr_pc_o=pc` and `npc_o=pc+4` in all states.

## Timing
- Reset values: `iREN=0`, `iaddr=PC_INIT`, `valid_o=0`, `instr_o=0`, `curr_pc_o=PC_INIT`, `npc_o=PC_INIT+4`, `pred_taken_o=0`, state IDLE, BTB all invalid.
- Latency: instruction output is combinational from `ihit`/`iload` in FETCH (same cycle). A hit stream sustains one instruction per cycle.
- Redirect penalty:
  - 0 extra cycles if the cache hits that cycle; the new address is issued next cycle.
  - During a miss, the miss must complete, then the new address is issued the cycle after `ihit`.
- Reset mid-miss: the request is abandoned; `iREN` drops asynchronously.

## Configuration
- `FETCH_BTB_EN` defined: a direct-mapped BTB with `BTB_ENTRIES` entries.
  - Index `pc[log2(N)+1:2]`; tag = remaining upper bits; one valid bit per entry.
  - Lookup on `pc`: a hit sets `next_pc=target` and `pred_taken_o=1` (the output is qualified by `valid_o`).
  - `btb_update` writes the entry at the next edge. A same-cycle lookup at the same index sees the old contents.
- `FETCH_BTB_EN` undefined: no BTB storage; `next_pc=pc+4`, `pred_taken_o=0`, and the `btb_*` inputs are ignored.

## Test plan
- Reset, then `ihit=1` every cycle with `iload=32'h1111_0000+addr`: first `valid_o` is 2 cycles after release; `curr_pc_o` runs 0, 4, 8; `npc_o` runs 4, 8, 12.
- `stall=1` for 3 cycles on a hit at PC 8: HOLD, `iREN=0`, `instr_o` stays 32'h1111_0008 and `valid_o=0`. `valid_o=1` comes the cycle `stall` drops, then PC 12 is fetched.
- Miss at PC 16 (`ihit=0` for 4 cycles) with `redirect=1`, `redirect_pc=32'h40` in cycle 2: `iaddr` stays 16 until `ihit`, no `valid_o`, next `iaddr=32'h40`.
- `PC_INIT=32'hFFFF_FFFC` with hits: `curr_pc_o` goes FFFF_FFFC → 0 and `npc_o` wraps to 0.
- `halt` during HOLD: `valid_o=0` forever and `iREN=0` until `nRST`.
- With `FETCH_BTB_EN`: update pc 8 → target 32'h100, then fetch from 0. The sequence is 0, 4, 8 (`pred_taken_o=1`), 32'h100. Without the macro the sequence is 0, 4, 8, 12.
